// File: rtl/ft_rx_frame_parser.sv
// ft_rx_frame_parser: pulls SYNC/LEN/payload frames out of the FT600 rx ring.
// Define FT_RX_CHECKSUM_EN to expect and check a trailing XOR checksum byte.
module ft_rx_frame_parser #(
  parameter int         RX_BUFFER       = 16,
  parameter int         RX_BUFFER_WIDTH = $clog2(RX_BUFFER),
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         TIMEOUT         = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*RX_BUFFER-1:0]     rx_buf_flat,
  input  logic [RX_BUFFER_WIDTH-1:0] rx_buf_written,
  output logic [RX_BUFFER_WIDTH-1:0] rx_buf_read,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic                       frame_done,
  output logic                       frame_ok,
  output logic [15:0]                err_count
);

  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TW   = (TLIM > 0) ? $clog2(TLIM + 1) : 1;

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;

  state_t        state, state_d;
  logic [7:0]    remaining;
  logic [TW-1:0] tcnt;
  logic [7:0]    rx_byte;
  logic          avail, take, load, fin, fin_ok;
`ifdef FT_RX_CHECKSUM_EN
  logic [7:0]    acc;
`endif

  assign avail   = rx_buf_read != rx_buf_written;
  assign rx_byte = rx_buf_flat[{rx_buf_read, 3'b000} +: 8];

  always_comb begin
    state_d = state;
    take    = 1'b0;
    load    = 1'b0;
    fin     = 1'b0;
    fin_ok  = 1'b0;
    unique case (state)
      HUNT: if (avail) begin
        take = 1'b1;
        if (rx_byte == SYNC_BYTE) state_d = LEN;
      end
      LEN: if (avail) begin
        take = 1'b1;
        if (rx_byte != 8'd0) begin
          state_d = PAYLOAD;
        end else begin
`ifdef FT_RX_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = HUNT;
          fin     = 1'b1;
          fin_ok  = 1'b1;
`endif
        end
      end
      PAYLOAD: if (avail && (!m_valid || m_ready)) begin
        take = 1'b1;
        load = 1'b1;
        if (remaining == 8'd1) begin
`ifdef FT_RX_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = HUNT;
          fin     = 1'b1;
          fin_ok  = 1'b1;
`endif
        end
      end
`ifdef FT_RX_CHECKSUM_EN
      CSUM: if (avail) begin
        take    = 1'b1;
        fin     = 1'b1;
        fin_ok  = rx_byte == acc;
        state_d = HUNT;
      end
`endif
      default: state_d = HUNT;
    endcase
    // stalled output also counts as idle: a wedged consumer aborts the frame
    if (TIMEOUT != 0 && state != HUNT && !take && tcnt == TW'(TLIM)) begin
      state_d = HUNT;
      fin     = 1'b1;
      fin_ok  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf_read <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_count   <= '0;
      remaining   <= '0;
      tcnt        <= '0;
    end else begin
      frame_done <= fin;
      frame_ok   <= fin_ok;
      if (fin && !fin_ok && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      if (take)
        rx_buf_read <= rx_buf_read + RX_BUFFER_WIDTH'(1);
      if (state_d == HUNT || take) tcnt <= '0;
      else                         tcnt <= tcnt + TW'(1);
      if (state == LEN && take) remaining <= rx_byte;
      else if (load)            remaining <= remaining - 8'd1;
      if (load) begin
        m_data  <= rx_byte;
        m_valid <= 1'b1;
        m_last  <= remaining == 8'd1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef FT_RX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (take) begin
      unique case (state)
        HUNT:    acc <= '0;
        LEN:     acc <= rx_byte;
        PAYLOAD: acc <= acc ^ rx_byte;
        default: acc <= acc;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ft_rx_frame_parser.sv
// tb_ft_rx_frame_parser: drives a ring producer and compares the parser
// against a frame-scanning reference model.
module tb_ft_rx_frame_parser;

  localparam int         N    = 16;
  localparam int         W    = 4;
  localparam int         TO   = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [8*N-1:0] rx_buf_flat;
  logic [W-1:0]   rx_buf_written = '0;
  logic [W-1:0]   rx_buf_read;
  logic [7:0]     m_data;
  logic           m_valid, m_last, frame_done, frame_ok;
  logic           m_ready = 1'b1;
  logic [15:0]    err_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] ring [N];
  logic [7:0] stim [$];
  logic [7:0] pay  [$];
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  logic       got_ok [$];
  logic       exp_ok [$];
  int         exp_err = 0;
  int         pushed  = 0;
  bit         stall    = 1'b0;
  bit         rand_rdy = 1'b0;

  ft_rx_frame_parser #(
    .RX_BUFFER(N), .RX_BUFFER_WIDTH(W),
    .SYNC_BYTE(SYNC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_buf_flat(rx_buf_flat),
    .rx_buf_written(rx_buf_written),
    .rx_buf_read(rx_buf_read),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) rx_buf_flat[8*i +: 8] = ring[i];

  always @(posedge clk) begin
    #2;
    if (stall)         m_ready = 1'b0;
    else if (rand_rdy) m_ready = ($urandom_range(3) != 0);
    else               m_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (frame_done) got_ok.push_back(frame_ok);
    end
  end

  // reference: scan the byte stream for SYNC, take LEN payload bytes
  task automatic model();
    int i = 0;
    while (i < stim.size()) begin
      if (stim[i] != SYNC) begin
        i++;
      end else begin
        int len = int'(stim[i+1]);
`ifdef FT_RX_CHECKSUM_EN
        logic [7:0] x = stim[i+1];
`endif
        for (int k = 0; k < len; k++) begin
          exp_q.push_back({(k == len - 1), stim[i+2+k]});
`ifdef FT_RX_CHECKSUM_EN
          x ^= stim[i+2+k];
`endif
        end
        i += 2 + len;
`ifdef FT_RX_CHECKSUM_EN
        exp_ok.push_back(stim[i] == x);
        i++;
`else
        exp_ok.push_back(1'b1);
`endif
        if (!exp_ok[$]) exp_err++;
      end
    end
  endtask

  task automatic add_frame(input bit good);
    logic [7:0] x = 8'(pay.size());
    stim.push_back(SYNC);
    stim.push_back(8'(pay.size()));
    foreach (pay[k]) begin
      stim.push_back(pay[k]);
      x ^= pay[k];
    end
`ifdef FT_RX_CHECKSUM_EN
    stim.push_back(good ? x : ~x);
`else
    if (!good) x = 8'd0;
`endif
  endtask

  task automatic clear_q();
    stim.delete(); pay.delete();
    got_q.delete(); exp_q.delete();
    got_ok.delete(); exp_ok.delete();
  endtask

  task automatic push(input int gap);
    foreach (stim[k]) begin
      int g = 0;
      while (rx_buf_written + W'(1) == rx_buf_read && g < 200) begin
        @(posedge clk); #1; g++;
      end
      if (g >= 200) begin
        total++; bad++;
        $display("FAIL push_wait: ring stayed full, read=%0d required progress", rx_buf_read);
      end
      ring[rx_buf_written] = stim[k];
      rx_buf_written = rx_buf_written + W'(1);
      pushed++;
      @(posedge clk); #1;
      repeat ($urandom_range(gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rx_buf_read != rx_buf_written || m_valid) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL drain: read=%0d written=%0d m_valid=%0b required empty+idle",
               rx_buf_read, rx_buf_written, m_valid);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_buf_written = '0;
    for (int i = 0; i < N; i++) ring[i] = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    pushed = 0; exp_err = 0;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    total += 7;
    if (rx_buf_read !== '0) begin bad++; $display("FAIL rst_read: got %0d want 0", rx_buf_read); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", m_valid); end
    if (m_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", m_last); end
    if (m_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", m_data); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    if (frame_ok !== 1'b0) begin bad++; $display("FAIL rst_ok: got %b want 0", frame_ok); end
    if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", err_count); end
  endtask

  task automatic test_basic();
    clear_q();
    pay = '{8'h11, 8'h22, 8'h33};
    add_frame(1'b1);
    model();
    push(0);
    drain();
    total += 4;
    if (got_q.size() !== 3) begin bad++; $display("FAIL basic_n: got %0d want 3", got_q.size()); end
    if (got_ok.size() !== 1) begin bad++; $display("FAIL basic_done: got %0d want 1", got_ok.size()); end
    if (rx_buf_read !== W'(pushed)) begin bad++; $display("FAIL basic_read: got %0d want %0d", rx_buf_read, W'(pushed)); end
    if (err_count !== 16'(exp_err)) begin bad++; $display("FAIL basic_err: got %0d want %0d", err_count, exp_err); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL basic_byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
    foreach (exp_ok[k]) if (k < got_ok.size()) begin
      total++;
      if (got_ok[k] !== exp_ok[k]) begin bad++; $display("FAIL basic_ok: got %b want %b", got_ok[k], exp_ok[k]); end
    end
  endtask

`ifdef FT_RX_CHECKSUM_EN
  task automatic test_bad_csum();
    clear_q();
    stim = '{SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    model();
    push(0);
    drain();
    total += 4;
    if (got_q.size() !== 3) begin bad++; $display("FAIL badcs_n: got %0d want 3", got_q.size()); end
    if (got_ok.size() !== 1) begin bad++; $display("FAIL badcs_done: got %0d want 1", got_ok.size()); end
    else if (got_ok[0] !== exp_ok[0]) begin bad++; $display("FAIL badcs_ok: got %b want %b", got_ok[0], exp_ok[0]); end
    if (err_count !== 16'(exp_err)) begin bad++; $display("FAIL badcs_err: got %0d want %0d", err_count, exp_err); end
    if (rx_buf_read !== W'(pushed)) begin bad++; $display("FAIL badcs_read: got %0d want %0d", rx_buf_read, W'(pushed)); end
  endtask
`endif

  task automatic test_garbage();
    clear_q();
    stim = '{8'h00, 8'hFF};
    add_frame(1'b1);
    model();
    push(1);
    drain();
    total += 4;
    if (got_q.size() !== 0) begin bad++; $display("FAIL garb_n: got %0d want 0", got_q.size()); end
    if (got_ok.size() !== 1) begin bad++; $display("FAIL garb_done: got %0d want 1", got_ok.size()); end
    else if (got_ok[0] !== 1'b1) begin bad++; $display("FAIL garb_ok: got %b want 1", got_ok[0]); end
    if (rx_buf_read !== W'(pushed)) begin bad++; $display("FAIL garb_read: got %0d want %0d", rx_buf_read, W'(pushed)); end
    if (err_count !== 16'(exp_err)) begin bad++; $display("FAIL garb_err: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    pay = '{8'h01, 8'h02};
    add_frame(1'b1);
    pay = '{8'hA5, 8'h5A, 8'h77};
    add_frame(1'b1);
    model();
    push(0);
    total++;
    if (rx_buf_read !== rx_buf_written) begin
      bad++; $display("FAIL b2b_pace: read %0d want %0d", rx_buf_read, rx_buf_written);
    end
    drain();
    total += 2;
    if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_n: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_ok.size() !== 2) begin bad++; $display("FAIL b2b_done: got %0d want 2", got_ok.size()); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] rd0;
    int n = 0;
    clear_q();
    for (int k = 0; k < 5; k++) pay.push_back(8'($urandom_range(255)));
    add_frame(1'b1);
    model();
    stall = 1'b1;
    push(0);
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    rd0 = rx_buf_read;
    for (int c = 0; c < 10; c++) begin
      total += 2;
      if (m_data !== exp_q[0][7:0] || m_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d: data %h v %b want %h v 1", c, m_data, m_valid, exp_q[0][7:0]);
      end
      if (rx_buf_read !== rd0) begin bad++; $display("FAIL stall_read%0d: got %0d want %0d", c, rx_buf_read, rd0); end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    drain();
    total += 2;
    if (got_q.size() !== 5) begin bad++; $display("FAIL stall_n: got %0d want 5", got_q.size()); end
    if (got_ok.size() !== 1) begin bad++; $display("FAIL stall_done: got %0d want 1", got_ok.size()); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL stall_byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int f = 0; f < 20; f++) begin
      int ng = $urandom_range(2);
      int ln = $urandom_range(6);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] b = 8'($urandom_range(255));
        stim.push_back(b == SYNC ? 8'h5A : b);
      end
      pay.delete();
      for (int k = 0; k < ln; k++) pay.push_back(8'($urandom_range(255)));
      add_frame($urandom_range(3) != 0);
    end
    model();
    rand_rdy = 1'b1;
    push(2);
    drain();
    rand_rdy = 1'b0;
    total += 4;
    if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_n: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (got_ok.size() !== exp_ok.size()) begin bad++; $display("FAIL rnd_done: got %0d want %0d", got_ok.size(), exp_ok.size()); end
    if (err_count !== 16'(exp_err)) begin bad++; $display("FAIL rnd_err: got %0d want %0d", err_count, exp_err); end
    if (rx_buf_read !== W'(pushed)) begin bad++; $display("FAIL rnd_read: got %0d want %0d", rx_buf_read, W'(pushed)); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd_byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
    foreach (exp_ok[k]) if (k < got_ok.size()) begin
      total++;
      if (got_ok[k] !== exp_ok[k]) begin bad++; $display("FAIL rnd_ok%0d: got %b want %b", k, got_ok[k], exp_ok[k]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 14; k++) stim.push_back(8'h00);
    pay = '{8'h44, 8'h55, 8'h66};
    add_frame(1'b1);
    model();
    push(0);
    drain();
    total += 3;
    if (rx_buf_read !== W'(pushed)) begin bad++; $display("FAIL wrap_read: got %0d want %0d", rx_buf_read, W'(pushed)); end
    if (got_q.size() !== 3) begin bad++; $display("FAIL wrap_n: got %0d want 3", got_q.size()); end
    if (got_ok.size() !== 1) begin bad++; $display("FAIL wrap_done: got %0d want 1", got_ok.size()); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL wrap_byte%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    clear_q();
    stim = '{SYNC, 8'h04, 8'h11};
    push(0);
    for (int c = 1; c < TO; c++) begin
      @(posedge clk); #1;
      if (frame_done) early++;
    end
    @(posedge clk); #1;
    exp_err++;
    total += 5;
    if (early !== 0) begin bad++; $display("FAIL to_early: %0d pulses before %0d idle cycles, want 0", early, TO); end
    if (frame_done !== 1'b1 || frame_ok !== 1'b0) begin
      bad++; $display("FAIL to_pulse: done %b ok %b want done 1 ok 0", frame_done, frame_ok);
    end
    if (err_count !== 16'(exp_err)) begin bad++; $display("FAIL to_err: got %0d want %0d", err_count, exp_err); end
    if (got_q.size() !== 1) begin bad++; $display("FAIL to_n: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== 9'h011) begin bad++; $display("FAIL to_byte: got %h want 011", got_q[0]); end
    @(posedge clk); #1;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL to_once: done %b want 0", frame_done); end
  endtask

  task automatic test_rst_mid_frame();
    clear_q();
    stim = '{SYNC, 8'h04, 8'h11, 8'h22};
    push(0);
    rst = 1'b1;
    rx_buf_written = '0;
    @(posedge clk); #1;
    total += 4;
    if (rx_buf_read !== '0 || err_count !== 16'd0) begin
      bad++; $display("FAIL mrst_cnt: read %0d err %0d want 0 0", rx_buf_read, err_count);
    end
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00) begin
      bad++; $display("FAIL mrst_out: v %b l %b d %h want 0 0 00", m_valid, m_last, m_data);
    end
    if (frame_done !== 1'b0 || frame_ok !== 1'b0) begin
      bad++; $display("FAIL mrst_done: done %b ok %b want 0 0", frame_done, frame_ok);
    end
    rst = 1'b0;
    got_ok.delete();
    repeat (TO + 4) begin @(posedge clk); #1; end
    if (got_ok.size() !== 0) begin bad++; $display("FAIL mrst_pulse: got %0d pulses want 0", got_ok.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef FT_RX_CHECKSUM_EN
    test_bad_csum();
`endif
    test_garbage();
    test_back_to_back();
    test_stall();
    test_random();
    test_wrap();
    test_timeout();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
